wash_seq: RTL and testbench
===========================

# wash_seq

Parametrised washing-machine program sequencer: the next-generation controller core behind the front-panel display and lamps. It divides the system clock to a 1 s tick and runs a mode-selected program through wash, rinse and spin phases. It drives the action code, the BCD remaining-time digits and a thermometer water-level bar. Compared with the fixed single-mode controller it adds run-time mode selection, pause/resume, abort, a done/re-arm handshake and parametrised timing and level width; the debouncer and the 4-digit display scanner remain external.

## Interface
- TICK_DIV, 100_000_000: clk cycles per second tick; must be divisible by LEVELS.
- SEQ_S, 10: wash, rinse and spin length in seconds for the small program.
- SEQ_M, 15: as above, medium program.
- SEQ_L, 20: as above, large program; 3*SEQ_L ≤ 99.
- SPIN_T, 15: spin length in seconds for the spin-only program; ≤ 99.
- LEVELS, 8: water-level bar width; ≥ 2.
- clk  in  1  system clock; one clock domain.
- rst  in  1  synchronous, active-low reset.
- on  in  1  power enable; 0 freezes all state and ignores start/abort.
- start  in  1  single-cycle debounced pulse: start / pause toggle / re-arm.
- abort  in  1  single-cycle pulse: return to IDLE.
- mode  in  2  00 spin-only, 01 small, 10 medium, 11 large; sampled at start.
- phase  out  2  00 idle, 01 wash, 10 rinse, 11 spin.
- action  out  4  0 idle, 1 rotate, 2 stew, 3 fill, 4 drain, 5 fwd spin, 6 rev spin, 10 done.
- secs_t  out  4  remaining seconds, BCD tens.
- secs_o  out  4  remaining seconds, BCD ones.
- level  out  LEVELS  thermometer water level; bit 0 is the bottom segment.
- paused  out  1  run is paused.
- done  out  1  program finished.

## Operation
- States: IDLE, RUN (with paused flag), DONE. All outputs are registered.
- IDLE: phase 0, action 0, level 0. secs loads the selected mode total every cycle: 3*SEQ for modes 01/10/11, SPIN_T for mode 00.
- IDLE + start: latch the mode. Mode 00 enters spin; other modes enter wash. Clear ph_sec, tick and step counters.
- ph_sec counts 0..len-1 within a phase. len is the latched SEQ value, or SPIN_T for spin-only.
- Wash action: ph_sec even → 1, odd → 2. level is forced to all ones.
- Rinse action by ph_sec mod 3: 0 → 3, 1 → 1, 2 → 4.
- Spin action by ph_sec mod 4: 0 → 5, 1 → 4, 2 → 6, 3 → 4.
- The second tick fires on the cycle where tick_cnt = TICK_DIV-1; tick_cnt then wraps to 0. On each tick:
  - BCD decrement of secs; when ones = 0 they go to 9 and tens decrement; 00 saturates.
  - ph_sec increments, or at len-1 goes to 0 and advances wash → rinse → spin.
- Tick with ph_sec = len-1 in spin: enter DONE. action 10, secs 00, phase stays 11, done 1.
- Level outside wash, driven by a step counter that wraps every TICK_DIV/LEVELS cycles. At each wrap:
  - during fill, level shifts left with a 1 entering bit 0;
  - during drain, it shifts right with a 0 entering the MSB;
  - other actions hold level. Shifts saturate naturally at all ones / all zeros.
- RUN + start: toggle paused. While paused, tick_cnt, step counter, ph_sec and all outputs hold.
- DONE + start: return to IDLE; done clears.
- abort in any state: next edge enters IDLE, paused 0, done 0, level 0. abort wins over a simultaneous start.
- on = 0: nothing changes; start and abort are ignored.
- mode changes during RUN have no effect until the next start.

## Timing
- Reset values at the first rising edge with rst = 0, regardless of state: phase 00, action 0, secs 0/0, level 0, paused 0, done 0, all counters 0, state IDLE. The IDLE preset appears on the first following cycle with on = 1.
- start is accepted at edge k. phase/action reflect the first step after edge k, and the first second tick occurs TICK_DIV on-cycles later.
- Phase and action change on the same edge as the tick that causes them; there is no extra latency.
- Total run from start to done = total × TICK_DIV on-and-unpaused cycles.

## Test plan
- TICK_DIV=8, LEVELS=4, mode 10, start:
  - secs 4/5 → 4/4 after 8 cycles;
  - phases 01 → 10 → 11 at ticks 15 and 30;
  - done=1, action 10, secs 0/0 at tick 45.
- Mode 01 rinse, from the start of a fill: level 1111 is forced in wash; at tick 10 rinse begins with fill (action 3) and level holds 1111; through the drain second (action 4) level goes 0111, 0011, 0001, 0000 at 2-cycle steps.
- Mode 00 start: phase 11 immediately, actions 5,4,6,4 repeating, secs 1/5 down to 0/0, done at tick 15.
- Pause mid-wash for 20 cycles, then start again: secs and action are frozen for exactly 20 cycles; total run extended by 20 cycles.
- abort and start in the same cycle during rinse: IDLE next edge, phase 00, paused 0, secs shows the mode preset.
- rst low mid-spin: all outputs are at reset values on the next edge; holding on=0 for 10 cycles during RUN leaves state unchanged.

Source files
------------

// File: rtl/wash_seq.sv
// Washing-machine program sequencer: a 1 s tick divider drives the wash/rinse/spin
// program and produces registered action, BCD remaining time and a level bar.
module wash_seq #(
  parameter int TICK_DIV = 100_000_000,
  parameter int SEQ_S    = 10,
  parameter int SEQ_M    = 15,
  parameter int SEQ_L    = 20,
  parameter int SPIN_T   = 15,
  parameter int LEVELS   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              on,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  output logic [1:0]        phase,
  output logic [3:0]        action,
  output logic [3:0]        secs_t,
  output logic [3:0]        secs_o,
  output logic [LEVELS-1:0] level,
  output logic              paused,
  output logic              done,
  output logic [1:0]        o_dbg_state
);

  localparam int STEP = TICK_DIV / LEVELS;
  localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW   = (STEP > 1) ? $clog2(STEP) : 1;

  localparam logic [1:0] PH_IDLE  = 2'd0;
  localparam logic [1:0] PH_WASH  = 2'd1;
  localparam logic [1:0] PH_RINSE = 2'd2;
  localparam logic [1:0] PH_SPIN  = 2'd3;

  localparam logic [3:0] ACT_IDLE   = 4'd0;
  localparam logic [3:0] ACT_ROTATE = 4'd1;
  localparam logic [3:0] ACT_STEW   = 4'd2;
  localparam logic [3:0] ACT_FILL   = 4'd3;
  localparam logic [3:0] ACT_DRAIN  = 4'd4;
  localparam logic [3:0] ACT_FWD    = 4'd5;
  localparam logic [3:0] ACT_REV    = 4'd6;
  localparam logic [3:0] ACT_DONE   = 4'd10;

  localparam logic [3:0] P0_T = 4'(SPIN_T / 10);
  localparam logic [3:0] P0_O = 4'(SPIN_T % 10);
  localparam logic [3:0] P1_T = 4'((3 * SEQ_S) / 10);
  localparam logic [3:0] P1_O = 4'((3 * SEQ_S) % 10);
  localparam logic [3:0] P2_T = 4'((3 * SEQ_M) / 10);
  localparam logic [3:0] P2_O = 4'((3 * SEQ_M) % 10);
  localparam logic [3:0] P3_T = 4'((3 * SEQ_L) / 10);
  localparam logic [3:0] P3_O = 4'((3 * SEQ_L) % 10);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t            r_state, w_state_nx;
  logic [1:0]        r_mode, w_mode_nx;
  logic [1:0]        r_phase, w_phase_nx;
  logic [3:0]        r_action, w_action_nx;
  logic [3:0]        r_secs_t, w_secs_t_nx;
  logic [3:0]        r_secs_o, w_secs_o_nx;
  logic [LEVELS-1:0] r_level, w_level_nx;
  logic              r_paused, w_paused_nx;
  logic              r_done, w_done_nx;
  logic [TW-1:0]     r_tick_cnt, w_tick_cnt_nx;
  logic [SW-1:0]     r_step_cnt, w_step_cnt_nx;
  logic [6:0]        r_ph_sec, w_ph_sec_nx;

  logic [3:0] w_pre_t, w_pre_o;
  logic [6:0] w_len;
  logic       w_tick, w_wrap;

  function automatic logic [3:0] act_of(input logic [1:0] ph, input logic [6:0] sec);
    logic [3:0] a;
    a = ACT_IDLE;
    case (ph)
      PH_WASH:  a = sec[0] ? ACT_STEW : ACT_ROTATE;
      PH_RINSE: begin
        case (sec % 7'd3)
          7'd0:    a = ACT_FILL;
          7'd1:    a = ACT_ROTATE;
          default: a = ACT_DRAIN;
        endcase
      end
      PH_SPIN: begin
        case (sec[1:0])
          2'd0:    a = ACT_FWD;
          2'd2:    a = ACT_REV;
          default: a = ACT_DRAIN;
        endcase
      end
      default: a = ACT_IDLE;
    endcase
    return a;
  endfunction

  always_comb begin
    w_pre_t = P0_T;
    w_pre_o = P0_O;
    case (mode)
      2'd1:    begin w_pre_t = P1_T; w_pre_o = P1_O; end
      2'd2:    begin w_pre_t = P2_T; w_pre_o = P2_O; end
      2'd3:    begin w_pre_t = P3_T; w_pre_o = P3_O; end
      default: begin w_pre_t = P0_T; w_pre_o = P0_O; end
    endcase
    w_len = 7'(SPIN_T);
    case (r_mode)
      2'd1:    w_len = 7'(SEQ_S);
      2'd2:    w_len = 7'(SEQ_M);
      2'd3:    w_len = 7'(SEQ_L);
      default: w_len = 7'(SPIN_T);
    endcase
  end

  assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));
  assign w_wrap = (r_step_cnt == SW'(STEP - 1));

  // Next-state and output logic; every value holds unless a branch below moves it.
  always_comb begin
    w_state_nx    = r_state;
    w_mode_nx     = r_mode;
    w_phase_nx    = r_phase;
    w_action_nx   = r_action;
    w_secs_t_nx   = r_secs_t;
    w_secs_o_nx   = r_secs_o;
    w_level_nx    = r_level;
    w_paused_nx   = r_paused;
    w_done_nx     = r_done;
    w_tick_cnt_nx = r_tick_cnt;
    w_step_cnt_nx = r_step_cnt;
    w_ph_sec_nx   = r_ph_sec;

    if (on) begin
      if (abort || (r_state == S_DONE && start) || r_state == S_IDLE) begin
        w_state_nx    = S_IDLE;
        w_phase_nx    = PH_IDLE;
        w_action_nx   = ACT_IDLE;
        w_level_nx    = '0;
        w_secs_t_nx   = w_pre_t;
        w_secs_o_nx   = w_pre_o;
        w_paused_nx   = 1'b0;
        w_done_nx     = 1'b0;
        w_tick_cnt_nx = '0;
        w_step_cnt_nx = '0;
        w_ph_sec_nx   = '0;
        if (!abort && r_state == S_IDLE && start) begin
          w_state_nx  = S_RUN;
          w_mode_nx   = mode;
          w_phase_nx  = (mode == 2'd0) ? PH_SPIN : PH_WASH;
          w_action_nx = act_of(w_phase_nx, 7'd0);
          w_level_nx  = (mode == 2'd0) ? '0 : '1;
        end
      end else if (r_state == S_RUN) begin
        if (start) w_paused_nx = ~r_paused;
        // A run advances on every edge that begins unpaused, including the pausing edge.
        if (!r_paused) begin
          w_tick_cnt_nx = w_tick ? '0 : r_tick_cnt + TW'(1);
          w_step_cnt_nx = w_wrap ? '0 : r_step_cnt + SW'(1);
          if (w_tick) begin
            if (r_secs_t == 4'd0 && r_secs_o == 4'd0) begin
              w_secs_o_nx = 4'd0;
            end else if (r_secs_o == 4'd0) begin
              w_secs_o_nx = 4'd9;
              w_secs_t_nx = r_secs_t - 4'd1;
            end else begin
              w_secs_o_nx = r_secs_o - 4'd1;
            end
            if (r_ph_sec == w_len - 7'd1) begin
              w_ph_sec_nx = '0;
              if (r_phase == PH_SPIN) begin
                w_state_nx  = S_DONE;
                w_done_nx   = 1'b1;
                w_secs_t_nx = 4'd0;
                w_secs_o_nx = 4'd0;
              end else begin
                w_phase_nx = r_phase + 2'd1;
              end
            end else begin
              w_ph_sec_nx = r_ph_sec + 7'd1;
            end
          end
          w_action_nx = (w_state_nx == S_DONE) ? ACT_DONE : act_of(w_phase_nx, w_ph_sec_nx);
          // Level shifts use the action shown during the step that just ended.
          if (w_phase_nx == PH_WASH) begin
            w_level_nx = '1;
          end else if (w_wrap) begin
            if (r_action == ACT_FILL)       w_level_nx = {r_level[LEVELS-2:0], 1'b1};
            else if (r_action == ACT_DRAIN) w_level_nx = {1'b0, r_level[LEVELS-1:1]};
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_mode     <= 2'd0;
      r_phase    <= PH_IDLE;
      r_action   <= ACT_IDLE;
      r_secs_t   <= 4'd0;
      r_secs_o   <= 4'd0;
      r_level    <= '0;
      r_paused   <= 1'b0;
      r_done     <= 1'b0;
      r_tick_cnt <= '0;
      r_step_cnt <= '0;
      r_ph_sec   <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_mode     <= w_mode_nx;
      r_phase    <= w_phase_nx;
      r_action   <= w_action_nx;
      r_secs_t   <= w_secs_t_nx;
      r_secs_o   <= w_secs_o_nx;
      r_level    <= w_level_nx;
      r_paused   <= w_paused_nx;
      r_done     <= w_done_nx;
      r_tick_cnt <= w_tick_cnt_nx;
      r_step_cnt <= w_step_cnt_nx;
      r_ph_sec   <= w_ph_sec_nx;
    end
  end

  assign phase       = r_phase;
  assign action      = r_action;
  assign secs_t      = r_secs_t;
  assign secs_o      = r_secs_o;
  assign level       = r_level;
  assign paused      = r_paused;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_wash_seq.sv
// Directed bench for wash_seq with TICK_DIV=8, LEVELS=4; expected values are hand-derived.
module tb_wash_seq;

  logic       clk;
  logic       rst;
  logic       on;
  logic       start;
  logic       abort;
  logic [1:0] mode;
  logic [1:0] phase;
  logic [3:0] action;
  logic [3:0] secs_t;
  logic [3:0] secs_o;
  logic [3:0] level;
  logic       paused;
  logic       done;
  logic [1:0] dbg_state;

  int n_checks;
  int n_errors;

  wash_seq #(
    .TICK_DIV(8), .SEQ_S(10), .SEQ_M(15), .SEQ_L(20), .SPIN_T(15), .LEVELS(4)
  ) dut (
    .clk(clk), .rst(rst), .on(on), .start(start), .abort(abort), .mode(mode),
    .phase(phase), .action(action), .secs_t(secs_t), .secs_o(secs_o),
    .level(level), .paused(paused), .done(done), .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    wait_edges(1);
    start = 1'b0;
  endtask

  task automatic check_secs(input string tag, input int t, input int o);
    check({tag, "_t"}, 32'(secs_t), 32'(t));
    check({tag, "_o"}, 32'(secs_o), 32'(o));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst   = 1'b0;
    on    = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    mode  = 2'd2;
    wait_edges(1);
    check("rst_phase", 32'(phase), 0);
    check("rst_action", 32'(action), 0);
    check_secs("rst_secs", 0, 0);
    check("rst_level", 32'(level), 0);
    check("rst_paused", 32'(paused), 0);
    check("rst_done", 32'(done), 0);
    rst = 1'b1;
    wait_edges(1);
    check_secs("idle_preset_m2", 4, 5);
    check("idle_phase", 32'(phase), 0);

    // medium program, full run
    pulse_start();
    check("m2_start_phase", 32'(phase), 1);
    check("m2_start_action", 32'(action), 1);
    check("m2_start_level", 32'(level), 4'hF);
    check_secs("m2_start_secs", 4, 5);
    wait_edges(7);
    check("m2_pre_tick_o", 32'(secs_o), 5);
    wait_edges(1);
    check_secs("m2_tick1", 4, 4);
    check("m2_tick1_action", 32'(action), 2);
    wait_edges(111);
    check("m2_before_rinse", 32'(phase), 1);
    wait_edges(1);
    check("m2_rinse_phase", 32'(phase), 2);
    check("m2_rinse_action", 32'(action), 3);
    check_secs("m2_rinse_secs", 3, 0);
    wait_edges(120);
    check("m2_spin_phase", 32'(phase), 3);
    check("m2_spin_action", 32'(action), 5);
    check_secs("m2_spin_secs", 1, 5);
    wait_edges(119);
    check("m2_pre_done", 32'(done), 0);
    check("m2_pre_done_o", 32'(secs_o), 1);
    wait_edges(1);
    check("m2_done", 32'(done), 1);
    check("m2_done_action", 32'(action), 10);
    check_secs("m2_done_secs", 0, 0);
    check("m2_done_phase", 32'(phase), 3);
    check("m2_done_state", 32'(dbg_state), 2);
    pulse_start();
    check("rearm_done", 32'(done), 0);
    check("rearm_phase", 32'(phase), 0);
    check_secs("rearm_secs", 4, 5);
    check("rearm_state", 32'(dbg_state), 0);

    // small program, level bar through rinse
    mode = 2'd1;
    wait_edges(1);
    check_secs("m1_preset", 3, 0);
    pulse_start();
    check("m1_wash_level", 32'(level), 4'hF);
    wait_edges(80);
    check("m1_rinse_phase", 32'(phase), 2);
    check("m1_fill_action", 32'(action), 3);
    check("m1_fill_level", 32'(level), 4'hF);
    wait_edges(16);
    check("m1_drain_action", 32'(action), 4);
    check("m1_drain_l0", 32'(level), 4'hF);
    wait_edges(2);
    check("m1_drain_l1", 32'(level), 4'h7);
    wait_edges(2);
    check("m1_drain_l2", 32'(level), 4'h3);
    wait_edges(2);
    check("m1_drain_l3", 32'(level), 4'h1);
    wait_edges(2);
    check("m1_drain_l4", 32'(level), 4'h0);
    check("m1_refill_action", 32'(action), 3);

    // abort with simultaneous start during rinse
    start = 1'b1;
    abort = 1'b1;
    wait_edges(1);
    start = 1'b0;
    abort = 1'b0;
    check("abort_phase", 32'(phase), 0);
    check("abort_action", 32'(action), 0);
    check("abort_paused", 32'(paused), 0);
    check("abort_level", 32'(level), 0);
    check_secs("abort_secs", 3, 0);
    check("abort_state", 32'(dbg_state), 0);

    // spin-only program
    mode = 2'd0;
    wait_edges(1);
    check_secs("m0_preset", 1, 5);
    pulse_start();
    check("m0_phase", 32'(phase), 3);
    check("m0_act0", 32'(action), 5);
    wait_edges(8);
    check("m0_act1", 32'(action), 4);
    check_secs("m0_secs1", 1, 4);
    wait_edges(8);
    check("m0_act2", 32'(action), 6);
    wait_edges(8);
    check("m0_act3", 32'(action), 4);
    wait_edges(8);
    check("m0_act4", 32'(action), 5);
    check_secs("m0_secs4", 1, 1);
    wait_edges(87);
    check("m0_pre_done", 32'(done), 0);
    check_secs("m0_pre_secs", 0, 1);
    wait_edges(1);
    check("m0_done", 32'(done), 1);
    check("m0_done_action", 32'(action), 10);
    check_secs("m0_done_secs", 0, 0);
    check("m0_level", 32'(level), 0);
    pulse_start();

    // pause for 20 cycles during wash, medium program
    mode = 2'd2;
    wait_edges(1);
    pulse_start();
    wait_edges(19);
    pulse_start();
    check("pause_on", 32'(paused), 1);
    check_secs("pause_secs", 4, 3);
    check("pause_action", 32'(action), 1);
    wait_edges(19);
    check("pause_hold", 32'(paused), 1);
    check_secs("pause_hold_secs", 4, 3);
    check("pause_hold_action", 32'(action), 1);
    pulse_start();
    check("resume", 32'(paused), 0);
    check("resume_o", 32'(secs_o), 3);
    wait_edges(3);
    check("resume_pre_tick", 32'(secs_o), 3);
    wait_edges(1);
    check_secs("resume_tick", 4, 2);
    check("resume_action", 32'(action), 2);
    wait_edges(335);
    check("pause_pre_done", 32'(done), 0);
    wait_edges(1);
    check("pause_done", 32'(done), 1);
    check_secs("pause_done_secs", 0, 0);
    pulse_start();

    // power-off freeze and reset mid-spin, small program
    mode = 2'd1;
    wait_edges(1);
    pulse_start();
    wait_edges(165);
    check("m1_spin_phase", 32'(phase), 3);
    check("m1_spin_action", 32'(action), 5);
    check_secs("m1_spin_secs", 1, 0);
    on = 1'b0;
    start = 1'b1;
    abort = 1'b1;
    wait_edges(1);
    start = 1'b0;
    abort = 1'b0;
    wait_edges(9);
    check("off_phase", 32'(phase), 3);
    check("off_action", 32'(action), 5);
    check_secs("off_secs", 1, 0);
    check("off_paused", 32'(paused), 0);
    check("off_state", 32'(dbg_state), 1);
    on = 1'b1;
    wait_edges(2);
    check("on_pre_tick", 32'(action), 5);
    check_secs("on_pre_secs", 1, 0);
    wait_edges(1);
    check("on_tick_action", 32'(action), 4);
    check_secs("on_tick_secs", 0, 9);
    rst = 1'b0;
    wait_edges(1);
    check("rst2_phase", 32'(phase), 0);
    check("rst2_action", 32'(action), 0);
    check_secs("rst2_secs", 0, 0);
    check("rst2_level", 32'(level), 0);
    check("rst2_done", 32'(done), 0);
    check("rst2_paused", 32'(paused), 0);
    check("rst2_state", 32'(dbg_state), 0);
    rst = 1'b1;
    wait_edges(1);
    check_secs("rst2_preset", 3, 0);

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
